// File: rtl/matrix_frame_streamer_pkg.sv
// Shared state type, default geometry and helper for the matrix frame streamer.
package matrix_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} stream_state_t;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_FRAME_WORDS = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RAM_LATENCY = 1;

  // The latency counter must be able to hold the value RAM_LATENCY itself.
  function automatic int lat_cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/matrix_frame_streamer_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/matrix_frame_streamer.sv
// Streams one frame of BRAM words to the Arduino matrix driver, one word per pump edge,
// with read-latency compensation, frame-done pulse, auto-rewind and overrun detection.
module matrix_frame_streamer
  import matrix_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pump,
  input  logic              dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              auto_rewind,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] matrix_out,
  output logic              matrix_valid,
  output logic              frame_done,
  output logic              overrun
);

  localparam int IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int LAT_W = lat_cnt_width(RAM_LATENCY);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
  localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(RAM_LATENCY);

  stream_state_t     state;
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] base_q;
  logic              pump_e;
  logic              dump_e;

  edge_sync #(.STAGES(SYNC_STAGES)) u_pump_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pump),
    .rise     (pump_e)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_dump_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (dump),
    .rise     (dump_e)
  );

  assign addr_b = base_q + ADDR_W'(idx);

  // dump has priority over everything, including a pump edge in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      lat_cnt      <= '0;
      base_q       <= '0;
      matrix_out   <= '0;
      matrix_valid <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (dump_e) begin
        state        <= IDLE;
        idx          <= '0;
        lat_cnt      <= '0;
        matrix_valid <= 1'b0;
        overrun      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pump_e) begin
              base_q  <= base_addr;
              idx     <= '0;
              lat_cnt <= '0;
              state   <= FETCH;
            end
          end
          FETCH: begin
            if (pump_e) overrun <= 1'b1;
            if (lat_cnt == LAT_DONE) begin
              matrix_out   <= q_b;
              matrix_valid <= 1'b1;
              frame_done   <= (idx == LAST_IDX);
              state        <= HOLD;
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
          HOLD: begin
            if (pump_e) begin
              matrix_valid <= 1'b0;
              lat_cnt      <= '0;
              if (idx == LAST_IDX) begin
                idx    <= '0;
                base_q <= base_addr;
                state  <= auto_rewind ? FETCH : DONE;
              end else begin
                idx   <= idx + IDX_W'(1);
                state <= FETCH;
              end
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_streamer.sv
// Self-checking bench: two streamers (RAM latency 1 and 2) share stimulus and are checked
// every cycle against a transaction-level model plus directed literal expectations.
module tb_matrix_frame_streamer;

  localparam int FW   = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pump;
  logic        dump;
  logic        auto_rewind;
  logic [15:0] base_addr;

  logic [15:0] ab0, ab1, qb0, qb1, mo0, mo1, pipe1;
  logic        mv0, mv1, fd0, fd1, ov0, ov1;

  logic [15:0] ab_a[2], mo_a[2];
  logic        mv_a[2], fd_a[2], ov_a[2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: one entry per DUT
  int          m_cyc = 0;
  logic [2:0]  m_ph = '0, m_dh = '0;
  logic        m_pe, m_de;
  int          m_ready_at[2] = '{-1, -1};
  bit          m_started[2]  = '{0, 0};
  bit          m_stopped[2]  = '{0, 0};
  int          m_word[2]     = '{0, 0};
  logic [15:0] m_base[2]     = '{16'h0, 16'h0};
  logic [15:0] m_out[2]      = '{16'h0, 16'h0};
  bit          m_valid[2]    = '{0, 0};
  bit          m_fd[2]       = '{0, 0};
  bit          m_ovr[2]      = '{0, 0};

  logic [15:0] cap_w[2][$];
  logic [15:0] cap_a[2][$];
  int          fd_cnt[2] = '{0, 0};
  logic        mv_prev[2] = '{1'b0, 1'b0};
  logic [15:0] expq[$];
  logic [15:0] expa[$];

  always #5 clk = ~clk;

  matrix_frame_streamer #(
    .ADDR_W(16), .DATA_W(16), .FRAME_WORDS(FW), .SYNC_STAGES(SYNC), .RAM_LATENCY(1)
  ) dut0 (
    .clk(clk), .reset(reset), .pump(pump), .dump(dump), .base_addr(base_addr),
    .auto_rewind(auto_rewind), .addr_b(ab0), .q_b(qb0), .matrix_out(mo0),
    .matrix_valid(mv0), .frame_done(fd0), .overrun(ov0)
  );

  matrix_frame_streamer #(
    .ADDR_W(16), .DATA_W(16), .FRAME_WORDS(FW), .SYNC_STAGES(SYNC), .RAM_LATENCY(2)
  ) dut1 (
    .clk(clk), .reset(reset), .pump(pump), .dump(dump), .base_addr(base_addr),
    .auto_rewind(auto_rewind), .addr_b(ab1), .q_b(qb1), .matrix_out(mo1),
    .matrix_valid(mv1), .frame_done(fd1), .overrun(ov1)
  );

  always_comb begin
    ab_a[0] = ab0;  ab_a[1] = ab1;
    mo_a[0] = mo0;  mo_a[1] = mo1;
    mv_a[0] = mv0;  mv_a[1] = mv1;
    fd_a[0] = fd0;  fd_a[1] = fd1;
    ov_a[0] = ov0;  ov_a[1] = ov1;
  end

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return (a ^ 16'h0100) + 16'h00A0;
  endfunction

  function automatic int rl_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  // BRAM read ports with one and two cycles of read latency
  always @(posedge clk) begin
    qb0   <= ram_word(ab0);
    pipe1 <= ram_word(ab1);
    qb1   <= pipe1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a pin edge takes effect SYNC+1 clocks after it is driven; a word becomes
  // visible RAM_LATENCY+1 clocks after its pump edge and equals the RAM content at base+word.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_cyc = 0; m_ph = '0; m_dh = '0;
        for (int d = 0; d < 2; d++) begin
          m_ready_at[d] = -1; m_started[d] = 0; m_stopped[d] = 0; m_word[d] = 0;
          m_base[d] = '0; m_out[d] = '0; m_valid[d] = 0; m_fd[d] = 0; m_ovr[d] = 0;
        end
      end else begin
        m_pe = m_ph[SYNC-1] && !m_ph[SYNC];
        m_de = m_dh[SYNC-1] && !m_dh[SYNC];
        m_ph = {m_ph[1:0], pump};
        m_dh = {m_dh[1:0], dump};
        m_cyc++;
        for (int d = 0; d < 2; d++) begin
          m_fd[d] = 0;
          if (m_de) begin
            m_ready_at[d] = -1; m_started[d] = 0; m_stopped[d] = 0;
            m_word[d] = 0; m_valid[d] = 0; m_ovr[d] = 0;
          end else if (m_ready_at[d] >= 0) begin
            if (m_pe) m_ovr[d] = 1;
            if (m_cyc == m_ready_at[d]) begin
              m_out[d]      = ram_word(16'(m_base[d] + 16'(m_word[d])));
              m_valid[d]    = 1;
              m_fd[d]       = (m_word[d] == FW - 1);
              m_ready_at[d] = -1;
            end
          end else if (m_pe && !m_stopped[d]) begin
            if (!m_started[d]) begin
              m_started[d]  = 1;
              m_base[d]     = base_addr;
              m_word[d]     = 0;
              m_ready_at[d] = m_cyc + rl_of(d) + 1;
            end else begin
              m_valid[d] = 0;
              if (m_word[d] == FW - 1) begin
                m_word[d] = 0;
                m_base[d] = base_addr;
                if (auto_rewind) m_ready_at[d] = m_cyc + rl_of(d) + 1;
                else m_stopped[d] = 1;
              end else begin
                m_word[d]++;
                m_ready_at[d] = m_cyc + rl_of(d) + 1;
              end
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of every captured word
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!reset) begin
          checkOutput($sformatf("valid_dut%0d", d), 32'(mv_a[d]), 32'(m_valid[d]));
          checkOutput($sformatf("frame_done_dut%0d", d), 32'(fd_a[d]), 32'(m_fd[d]));
          checkOutput($sformatf("overrun_dut%0d", d), 32'(ov_a[d]), 32'(m_ovr[d]));
          checkOutput($sformatf("matrix_out_dut%0d", d), 32'(mo_a[d]), 32'(m_out[d]));
          if (m_ready_at[d] >= 0)
            checkOutput($sformatf("addr_b_dut%0d", d), 32'(ab_a[d]),
                        32'(16'(m_base[d] + 16'(m_word[d]))));
          if (mv_a[d] && !mv_prev[d]) begin
            cap_w[d].push_back(mo_a[d]);
            cap_a[d].push_back(ab_a[d]);
          end
          if (fd_a[d]) fd_cnt[d]++;
        end
        mv_prev[d] = mv_a[d] && !reset;
      end
    end
  end

  task automatic applyStimulus(input logic p, input logic dm, input int gap);
    @(negedge clk);
    pump = p;
    dump = dm;
    @(negedge clk);
    pump = 1'b0;
    dump = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clearLog();
    for (int d = 0; d < 2; d++) begin
      cap_w[d].delete();
      cap_a[d].delete();
      fd_cnt[d] = 0;
    end
    expq.delete();
    expa.delete();
  endtask

  task automatic checkLog(input string name);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_count_dut%0d", name, d), 32'(cap_w[d].size()), 32'(expq.size()));
      for (int i = 0; i < expq.size(); i++) begin
        if (i < cap_w[d].size()) begin
          checkOutput($sformatf("%s_word%0d_dut%0d", name, i, d), 32'(cap_w[d][i]), 32'(expq[i]));
          if (i < expa.size())
            checkOutput($sformatf("%s_addr%0d_dut%0d", name, i, d), 32'(cap_a[d][i]), 32'(expa[i]));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat0, lat1;
    reset = 1'b1; pump = 1'b0; dump = 1'b0;
    base_addr = 16'h0100; auto_rewind = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_valid", 32'(mv_a[d]), 32'h0);
      checkOutput("reset_out", 32'(mo_a[d]), 32'h0);
      checkOutput("reset_addr", 32'(ab_a[d]), 32'h0);
      checkOutput("reset_overrun", 32'(ov_a[d]), 32'h0);
      checkOutput("reset_frame_done", 32'(fd_a[d]), 32'h0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] one-shot frame, 5 pumps then one extra");
    clearLog();
    repeat (5) applyStimulus(1'b1, 1'b0, 10);
    expq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    expa = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    checkLog("oneshot");
    for (int d = 0; d < 2; d++) begin
      checkOutput("oneshot_frame_done_count", 32'(fd_cnt[d]), 32'd1);
      checkOutput("oneshot_done_valid", 32'(mv_a[d]), 32'h0);
      checkOutput("oneshot_done_overrun", 32'(ov_a[d]), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 10);
    for (int d = 0; d < 2; d++) begin
      checkOutput("done_ignores_pump_valid", 32'(mv_a[d]), 32'h0);
      checkOutput("done_ignores_pump_overrun", 32'(ov_a[d]), 32'h0);
    end

    $display("[TB] auto-rewind frame, 6 pumps");
    auto_rewind = 1'b1;
    applyStimulus(1'b0, 1'b1, 6);
    clearLog();
    repeat (6) applyStimulus(1'b1, 1'b0, 10);
    expq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A0, 16'h00A1};
    expa = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0100, 16'h0101};
    checkLog("rewind");
    for (int d = 0; d < 2; d++)
      checkOutput("rewind_frame_done_count", 32'(fd_cnt[d]), 32'd1);

    $display("[TB] pump-to-valid latency");
    auto_rewind = 1'b0;
    applyStimulus(1'b0, 1'b1, 6);
    lat0 = -1;
    lat1 = -1;
    @(negedge clk);
    pump = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) pump = 1'b0;
      if (mv0 && lat0 < 0) lat0 = k;
      if (mv1 && lat1 < 0) lat1 = k;
    end
    checkOutput("latency_rl1", 32'(lat0 - (SYNC + 1)), 32'd2);
    checkOutput("latency_rl2", 32'(lat1 - (SYNC + 1)), 32'd3);
    checkOutput("latency_word_rl1", 32'(mo0), 32'h00A0);
    checkOutput("latency_word_rl2", 32'(mo1), 32'h00A0);

    $display("[TB] overrun from a pump during fetch");
    applyStimulus(1'b0, 1'b1, 6);
    clearLog();
    @(negedge clk); pump = 1'b1;
    @(negedge clk); pump = 1'b0;
    @(negedge clk); pump = 1'b1;
    @(negedge clk); pump = 1'b0;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 2; d++)
      checkOutput("overrun_set", 32'(ov_a[d]), 32'h1);
    applyStimulus(1'b1, 1'b0, 10);
    expq = '{16'h00A0, 16'h00A1};
    checkLog("overrun_single_advance");
    for (int d = 0; d < 2; d++)
      checkOutput("overrun_sticky", 32'(ov_a[d]), 32'h1);
    applyStimulus(1'b0, 1'b1, 6);
    for (int d = 0; d < 2; d++) begin
      checkOutput("dump_clears_overrun", 32'(ov_a[d]), 32'h0);
      checkOutput("dump_clears_valid", 32'(mv_a[d]), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 10);
    for (int d = 0; d < 2; d++)
      checkOutput("restart_from_word0", 32'(mo_a[d]), 32'h00A0);

    $display("[TB] address wrap at top of BRAM");
    base_addr = 16'hFFFE;
    applyStimulus(1'b0, 1'b1, 6);
    clearLog();
    repeat (4) applyStimulus(1'b1, 1'b0, 10);
    expq = '{16'hFF9E, 16'hFF9F, 16'h01A0, 16'h01A1};
    expa = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    checkLog("wrap");

    $display("[TB] simultaneous dump and pump mid-frame");
    applyStimulus(1'b0, 1'b1, 6);
    repeat (2) applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 10);
    for (int d = 0; d < 2; d++) begin
      checkOutput("dump_wins_valid", 32'(mv_a[d]), 32'h0);
      checkOutput("dump_wins_overrun", 32'(ov_a[d]), 32'h0);
      checkOutput("dump_wins_addr", 32'(ab_a[d]), 32'hFFFE);
      checkOutput("dump_wins_out_kept", 32'(mo_a[d]), 32'hFF9F);
    end
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 0);

    $display("[TB] reset asserted during fetch");
    @(negedge clk);
    pump = 1'b1;
    repeat (3) @(posedge clk);
    pump = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput("midfetch_reset_out", 32'(mo_a[d]), 32'h0);
      checkOutput("midfetch_reset_addr", 32'(ab_a[d]), 32'h0);
      checkOutput("midfetch_reset_valid", 32'(mv_a[d]), 32'h0);
      checkOutput("midfetch_reset_overrun", 32'(ov_a[d]), 32'h0);
      checkOutput("midfetch_reset_frame_done", 32'(fd_a[d]), 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
